// File: rtl/chan_stream_demux.sv
// chan_stream_demux: framed byte stream parser feeding per-channel sample FIFOs
module chan_stream_demux #(
  parameter int NUM_CH = 2,
  parameter int SAMPLE_BYTES = 1,
  parameter int DEPTH_WIDTH = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_CH-1:0]               rd_en,
  output logic [NUM_CH*8*SAMPLE_BYTES-1:0] rd_data,
  output logic [NUM_CH-1:0]               empty,
  output logic [NUM_CH-1:0]               full,
  output logic [15:0]                     frame_cnt,
  output logic [7:0]                      drop_cnt
);
  localparam int SW = 8 * SAMPLE_BYTES;
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int IW = SAMPLE_BYTES > 1 ? $clog2(SAMPLE_BYTES) : 1;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  typedef enum logic [1:0] {HUNT, CHAN, LEN, PAYLOAD} state_t;
  state_t st, nxt;
  logic [CW-1:0] ch;
  logic drop;
  logic [8:0] rem;
  logic [IW-1:0] idx;
  logic [SW-1:0] asm_q, sample;
  logic acc, done_s, last, push;
  assign acc = in_valid & in_ready;
  assign done_s = acc && st == PAYLOAD && idx == IW'(SAMPLE_BYTES - 1);
  assign last = done_s && rem == 9'd1;
  assign push = done_s && !drop;
  // the completing byte goes straight into the pushed word, not via asm_q
  always_comb begin
    sample = asm_q;
    sample[int'(idx)*8 +: 8] = in_data;
  end
  always_ff @(posedge clk) st <= rst ? HUNT : nxt;
  always_comb begin
    nxt = st;
    if (acc)
      unique case (st)
        HUNT:    nxt = in_data == SYNC_BYTE ? CHAN : HUNT;
        CHAN:    nxt = LEN;
        LEN:     nxt = PAYLOAD;
        PAYLOAD: nxt = last ? HUNT : PAYLOAD;
      endcase
  end
  always_comb in_ready = !(st == PAYLOAD && !drop && full[ch]);
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
      drop <= 1'b0;
      rem <= '0;
      idx <= '0;
      asm_q <= '0;
      frame_cnt <= '0;
      drop_cnt <= '0;
    end else if (acc) begin
      if (st == CHAN) begin
        ch <= in_data[CW-1:0];
        drop <= in_data >= 8'(NUM_CH);
      end
      if (st == LEN) begin
        rem <= in_data == 8'd0 ? 9'd256 : {1'b0, in_data};
        idx <= '0;
      end
      if (st == PAYLOAD) begin
        asm_q[int'(idx)*8 +: 8] <= in_data;
        idx <= done_s ? '0 : idx + 1'b1;
        if (done_s) rem <= rem - 9'd1;
        if (last && !drop) frame_cnt <= frame_cnt + 16'd1;
        if (last && drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    logic [SW-1:0] mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wp, rp;
    logic [DEPTH_WIDTH:0] cnt;
    logic [SW-1:0] rd_q;
    logic wr, rd;
    assign wr = push && ch == CW'(g);
    assign rd = rd_en[g] && !empty[g];
    assign empty[g] = cnt == '0;
    assign full[g] = cnt == (DEPTH_WIDTH+1)'(DEPTH);
    assign rd_data[g*SW +: SW] = rd_q;
    always_ff @(posedge clk) if (wr) mem[wp] <= sample;
    always_ff @(posedge clk) begin
      if (rst) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        rd_q <= '0;
      end else begin
        if (wr) wp <= wp + 1'b1;
        if (rd) begin
          rp <= rp + 1'b1;
          rd_q <= mem[rp];
        end
        cnt <= cnt + (DEPTH_WIDTH+1)'(wr) - (DEPTH_WIDTH+1)'(rd);
      end
    end
  end
endmodule

// File: doc/chan_stream_demux.md
Name: chan_stream_demux

Overview:
- Next-generation front end between the FT245 simple-interface RX byte stream and the modulators.
- Replaces the single-channel byte FIFO with a framed, multi-channel demultiplexer.
- Parses a sync/channel/length header, assembles multi-byte samples little-endian, and writes each sample into a per-channel FIFO.
- Each channel FIFO presents a sample/empty/read interface to one modulator instance.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- SAMPLE_BYTES, 1, bytes per sample (1..4); SW = 8*SAMPLE_BYTES.
- DEPTH_WIDTH, 6, log2 of per-channel FIFO depth in samples.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_data  in  8  RX byte from FT245 simple interface
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- rd_en  in  NUM_CH  per-channel read strobe from modulator
- rd_data  out  NUM_CH*SW  per-channel sample; channel k at bits [k*SW +: SW]
- empty  out  NUM_CH  per-channel FIFO empty
- full  out  NUM_CH  per-channel FIFO full
- frame_cnt  out  16  completed good frames, wraps
- drop_cnt  out  8  dropped frames, saturates at 255

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM goes to HUNT.
  - All FIFOs emptied: empty=all 1, full=0, rd_data=0.
  - in_ready=1; frame_cnt=0, drop_cnt=0; sample assembly register cleared.
- Frame format: SYNC_BYTE, CHAN byte, LEN byte, then N*SAMPLE_BYTES payload bytes.
  - N = LEN, except LEN=0 means N=256.
- FSM states:
  - HUNT: discard bytes until in_data==SYNC_BYTE accepted, then go to CHAN.
  - CHAN: latch ch=in_data. drop flag = (in_data >= NUM_CH). Go to LEN.
  - LEN: latch remaining-sample counter (9 bits) = N and byte index = 0. Go to PAYLOAD.
  - PAYLOAD: each accepted byte is stored at byte lane [idx*8 +: 8] (little-endian); idx increments.
    - When idx == SAMPLE_BYTES-1, the sample is complete: push it to FIFO[ch] unless dropping, reset idx to 0, decrement the remaining counter.
    - When the last sample completes, go to HUNT. Increment frame_cnt if not dropping, else increment drop_cnt (saturating).
- Backpressure: in_ready=0 only in PAYLOAD, when not dropping, and full[ch]=1. In all other cases in_ready=1.
  - Dropped frames consume payload at full rate and never write any FIFO.
- Each FIFO: depth 2^DEPTH_WIDTH samples, circular pointers with wrap, occupancy counter of DEPTH_WIDTH+1 bits.
  - full = (count == depth); empty = (count == 0).
- Read:
  - rd_en[k] & !empty[k]: rd_data lane k is registered with the head sample 1 cycle later; read pointer advances.
  - rd_en on empty: ignored, rd_data holds its value.
- Simultaneous read and write on the same channel in the same cycle: both take effect, count unchanged.
  - A write on a full FIFO cannot occur because of in_ready. The read frees a slot, but in_ready still reflects the registered full flag for that cycle.
- No header timeout. A byte equal to SYNC_BYTE inside a payload is treated as data.
- Counters update on the cycle the frame's last byte is accepted.
- Reset asserted mid-frame: the partial frame is abandoned, FIFO contents are lost, and no counters change other than being zeroed.
- Latency: from acceptance of the last byte of a sample to empty[ch] falling is 1 cycle.

Test Plan:
- NUM_CH=2, SAMPLE_BYTES=1. Send A5 01 03 10 20 30 → ch1 reads 10, 20, 30 in order; ch0 stays empty; frame_cnt=1.
- SAMPLE_BYTES=2. Send A5 00 02 34 12 78 56 → ch0 reads 1234 then 5678; empty[0] falls 1 cycle after byte 12 is accepted.
- Send garbage 00 FF then A5 05 01 AA (channel 5 invalid) → in_ready stays 1; drop_cnt=1; no FIFO write. A following valid frame is parsed correctly.
- DEPTH_WIDTH=2, no reads. Send a 6-sample frame to ch0 → full[0]=1 after 4 samples and in_ready=0. Then issue 2 reads → remaining 2 samples are accepted; total order is preserved.
- LEN=00 frame to ch0 with reads enabled → exactly 256 samples are delivered; FSM returns to HUNT; pointer wrap occurs correctly.
- Assert rst after A5 00 02 11 → empty=all 1, frame_cnt=0. A new frame A5 00 01 22 yields only 22.
